// File: rtl/arb_pkg.sv
// Shared types and sizes for the round-robin select arbiter and its picker.
package arb_pkg;

  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request after ptr, wrapping around.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  logic [IDX_W-1:0]  start;
  logic [NUM_CH-1:0] rot;
  logic [IDX_W-1:0]  off;

  assign start = ptr + IDX_W'(1);

  // rot[0] is the highest-priority channel; index arithmetic wraps mod NUM_CH
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rot[i] = req[start + IDX_W'(i)];
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign idx = start + off;
  assign any = |req;

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter feeding a 2x4 select decoder: one grant at a time,
// held until release/drop/timeout, always followed by an idle gap.
module rr_select_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic              enable,
  output logic              a0,
  output logic              a1,
  output logic              timeout
);

  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  arb_state_e     state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic           enable_q, enable_d;
  logic           timeout_q, timeout_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             release_now;
  logic             timer_hit;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign release_now = done || !req[idx_q];
  assign timer_hit   = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

  // A release coinciding with the timer limit wins, so no timeout pulse then
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    enable_d  = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          idx_d    = pick_idx;
          ptr_d    = pick_idx;
          enable_d = 1'b1;
          timer_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        enable_d = 1'b1;
        if (timer_q != TIMER_MAX) timer_d = timer_q + TW'(1);
        if (release_now) begin
          enable_d = 1'b0;
          state_d  = GAP;
        end else if (timer_hit) begin
          enable_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ptr resets to the last channel so the first search starts at channel 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      ptr_q     <= IDX_W'(NUM_CH - 1);
      idx_q     <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      enable_q  <= enable_d;
      timeout_q <= timeout_d;
    end
  end

  assign enable  = enable_q;
  assign a0      = idx_q[1];
  assign a1      = idx_q[0];
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Scenario bench for rr_select_arbiter (TIMEOUT=4); expected output vectors
// {enable,a0,a1,timeout} are queued per cycle and popped after each edge.
module tb_rr_select_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       enable;
  logic       a0;
  logic       a1;
  logic       timeout;

  typedef struct {
    logic [3:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  rr_select_arbiter #(.TIMEOUT(4), .TW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .enable  (enable),
    .a0      (a0),
    .a1      (a1),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    #1;
    exp_q.push_back('{4'b0000, "reset_async"});
    e = exp_q.pop_front();
    check_cnt++;
    if ({enable, a0, a1, timeout} !== e.v)
      $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      exp_q.push_back('{4'b0000, $sformatf("reset_idle_c%0d", c)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_cnt++;
      if ({enable, a0, a1, timeout} !== e.v)
        $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_grant();
    logic [3:0] rq [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic       dn [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] ex [5] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    exp_t e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req  = rq[c];
      done = dn[c];
      exp_q.push_back('{ex[c], $sformatf("single_grant_c%0d", c)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_cnt++;
      if ({enable, a0, a1, timeout} !== e.v)
        $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
      else pass_cnt++;
    end
  endtask

  task automatic test_done_idle();
    logic [3:0] rq [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    logic       dn [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] ex [5] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    exp_t e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req  = rq[c];
      done = dn[c];
      exp_q.push_back('{ex[c], $sformatf("done_idle_c%0d", c)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_cnt++;
      if ({enable, a0, a1, timeout} !== e.v)
        $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
      else pass_cnt++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_t e;
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        done = (c == 1);
        exp_q.push_back('{{(c == 0), seq[g], 1'b0}, $sformatf("rr_g%0d_c%0d", g, c)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_cnt++;
        if ({enable, a0, a1, timeout} !== e.v)
          $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
        else pass_cnt++;
      end
    end
    done = 1'b0;
  endtask

  task automatic test_timeout();
    logic [3:0] rq [13] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                            4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic       dn [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] ex [13] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0101, 4'b0100, 4'b1100,
                            4'b1100, 4'b1100, 4'b1100, 4'b0100, 4'b0100, 4'b0100};
    exp_t e;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      req  = rq[c];
      done = dn[c];
      exp_q.push_back('{ex[c], $sformatf("timeout_c%0d", c)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_cnt++;
      if ({enable, a0, a1, timeout} !== e.v)
        $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
      else pass_cnt++;
    end
  endtask

  task automatic test_req_drop();
    logic [3:0] rq [7] = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    logic [3:0] ex [7] = '{4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b1110, 4'b0110, 4'b0110};
    exp_t e;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req  = rq[c];
      done = 1'b0;
      exp_q.push_back('{ex[c], $sformatf("req_drop_c%0d", c)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_cnt++;
      if ({enable, a0, a1, timeout} !== e.v)
        $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_busy();
    exp_t e;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back('{4'b1100, $sformatf("mid_rst_busy_c%0d", c)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_cnt++;
      if ({enable, a0, a1, timeout} !== e.v)
        $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
      else pass_cnt++;
    end
    #2;
    rst = 1'b1;
    exp_q.push_back('{4'b0000, "mid_rst_async_drop"});
    #1;
    e = exp_q.pop_front();
    check_cnt++;
    if ({enable, a0, a1, timeout} !== e.v)
      $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
    else pass_cnt++;
    req = 4'b0110;
    exp_q.push_back('{4'b0000, "mid_rst_held"});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_cnt++;
    if ({enable, a0, a1, timeout} !== e.v)
      $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
    else pass_cnt++;
    rst = 1'b0;
    exp_q.push_back('{4'b1010, "mid_rst_first_grant_ch1"});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_cnt++;
    if ({enable, a0, a1, timeout} !== e.v)
      $display("[TB] FAIL %s: got %b expected %b", e.name, {enable, a0, a1, timeout}, e.v);
    else pass_cnt++;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    $display("[TB] starting rr_select_arbiter scenarios");
    test_reset();
    test_single_grant();
    test_done_idle();
    test_round_robin();
    test_timeout();
    test_req_drop();
    test_reset_mid_busy();
    if (exp_q.size() != 0) begin
      check_cnt++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
